// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and exception/interrupt sequencer for the M stage.
// Holds SR/Cause/EPC/PRId and issues a one-cycle flush with a redirect PC.
// Ports: clk, reset (sync, active-high); M-stage info valid_m/pc_m/bd_m/
//   exc_code_m/eret_m; hwint; mtc0/mfc0 cp0_we/cp0_addr/cp0_din;
//   outputs cp0_dout, epc_out, flush, redirect_pc, exl.
// Optional CP0_COUNT_EN adds Count(9)/Compare(11) and a timer on hwint[5].
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00004180,
  parameter logic [31:0] PRID_VAL     = 32'h20180103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_din,
  input  logic        eret_m,
  output logic [31:0] cp0_dout,
  output logic [31:0] epc_out,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic        flush_q, flush_d;
  logic [31:0] redir_q, redir_d;

  logic [5:0]  hw_eff;
  logic        int_req;
  logic        exc_req;
  logic        take_int;
  logic        take_exc;
  logic        take_eret;
  logic        take_wr;

`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        tpend_q, tpend_d;

  // Timer pending is merged before both IP sampling and IM masking.
  assign hw_eff = {hwint[5] | tpend_q, hwint[4:0]};
`else
  assign hw_eff = hwint;
`endif

  assign int_req = (|(hw_eff & im_q)) & ie_q & ~exl_q;
  assign exc_req = valid_m & (exc_code_m != 5'd0);

  // Priority resolution only applies in RUN; FLUSH ignores the M stage.
  assign take_int  = (state_q == RUN) & int_req;
  assign take_exc  = (state_q == RUN) & ~int_req & exc_req;
  assign take_eret = (state_q == RUN) & ~int_req & ~exc_req
                   & valid_m & eret_m;
  assign take_wr   = (state_q == RUN) & ~int_req & ~exc_req
                   & ~(valid_m & eret_m) & valid_m & cp0_we;

  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    exl_d   = exl_q;
    ie_d    = ie_q;
    bd_d    = bd_q;
    ip_d    = hw_eff;
    exc_d   = exc_q;
    epc_d   = epc_q;
    flush_d = 1'b0;
    redir_d = redir_q;
    unique case (state_q)
      RUN: begin
        if (take_int | take_exc) begin
          exc_d = take_int ? 5'd0 : exc_code_m;
          // A nested entry keeps the original return point.
          if (!exl_q) begin
            epc_d = bd_m ? (pc_m - 32'd4) : pc_m;
            bd_d  = bd_m;
          end
          exl_d   = 1'b1;
          redir_d = HANDLER_ADDR;
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (take_eret) begin
          exl_d   = 1'b0;
          redir_d = epc_q;
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (take_wr) begin
          if (cp0_addr == 5'd12) begin
            im_d  = cp0_din[15:10];
            exl_d = cp0_din[1];
            ie_d  = cp0_din[0];
          end
          if (cp0_addr == 5'd14) begin
            epc_d = {cp0_din[31:2], 2'b00};
          end
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

`ifdef CP0_COUNT_EN
  always_comb begin
    count_d = count_q + 32'd1;
    cmp_d   = cmp_q;
    tpend_d = tpend_q | (count_q == cmp_q);
    if (take_wr && cp0_addr == 5'd9) begin
      count_d = cp0_din;
    end
    if (take_wr && cp0_addr == 5'd11) begin
      cmp_d   = cp0_din;
      tpend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
      cmp_q   <= 32'd0;
      tpend_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      tpend_q <= tpend_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      im_q    <= 6'h3f;
      exl_q   <= 1'b0;
      ie_q    <= 1'b1;
      bd_q    <= 1'b0;
      ip_q    <= 6'd0;
      exc_q   <= 5'd0;
      epc_q   <= 32'd0;
      flush_q <= 1'b0;
      redir_q <= 32'd0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      exl_q   <= exl_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      ip_q    <= ip_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
    end
  end

  // Plain register read; no forwarding of a same-cycle mtc0.
  always_comb begin
    cp0_dout = 32'd0;
    unique case (cp0_addr)
      5'd12: cp0_dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13: cp0_dout = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
      5'd14: cp0_dout = epc_q;
      5'd15: cp0_dout = PRID_VAL;
`ifdef CP0_COUNT_EN
      5'd9:  cp0_dout = count_q;
      5'd11: cp0_dout = cmp_q;
`endif
      default: cp0_dout = 32'd0;
    endcase
  end

  assign epc_out     = epc_q;
  assign flush       = flush_q;
  assign redirect_pc = redir_q;
  assign exl         = exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed table-driven bench for cp0_exc_ctrl.
// Vectors carry inputs and expected post-edge outputs; corner cases by hand.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h20180103;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hwint;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din;
  logic        eret_m;
  logic [31:0] cp0_dout;
  logic [31:0] epc_out;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        exl;

  int n_cmp = 0;
  int n_err = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m),
    .bd_m(bd_m), .exc_code_m(exc_code_m), .hwint(hwint),
    .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_din(cp0_din),
    .eret_m(eret_m), .cp0_dout(cp0_dout), .epc_out(epc_out),
    .flush(flush), .redirect_pc(redirect_pc), .exl(exl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        eret;
    logic        e_flush;
    logic [31:0] e_redir;
    logic [31:0] e_epc;
    logic        e_exl;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic v, logic [31:0] pc, logic bd, logic [4:0] exc,
    logic [5:0] hw, logic we, logic [4:0] addr, logic [31:0] din,
    logic er, logic ef, logic [31:0] erd, logic [31:0] eep,
    logic ex, logic [31:0] edo);
    vec_t r;
    r.valid = v;  r.pc = pc;     r.bd = bd;     r.exc = exc;
    r.hw = hw;    r.we = we;     r.addr = addr; r.din = din;
    r.eret = er;  r.e_flush = ef; r.e_redir = erd;
    r.e_epc = eep; r.e_exl = ex; r.e_dout = edo;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    valid_m = 0; pc_m = 0; bd_m = 0; exc_code_m = 0; hwint = 0;
    cp0_we = 0; cp0_addr = 5'd12; cp0_din = 0; eret_m = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;

    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redir", redirect_pc, 32'd0);
    chk("rst_epc", epc_out, 32'd0);
    chk("rst_exl", {31'd0, exl}, 32'd0);
    cp0_addr = 5'd12; #1;
    chk("rst_sr", cp0_dout, 32'h0000fc01);
    cp0_addr = 5'd15; #1;
    chk("rst_prid", cp0_dout, PRID);
    cp0_addr = 5'd13; #1;
    chk("rst_cause", cp0_dout, 32'd0);

    // v pc bd exc hw we addr din eret | flush redir epc exl dout
    vt.push_back(mk(0,0,0,0,0,0,12,0,0, 0,0,0,0,32'hfc01));
    vt.push_back(mk(1,32'h3010,0,4,0,0,13,0,0,
                    1,32'h4180,32'h3010,1,32'h10));
    vt.push_back(mk(0,0,0,0,0,0,14,0,0,
                    0,32'h4180,32'h3010,1,32'h3010));
    vt.push_back(mk(1,32'h3014,0,0,0,0,12,0,1,
                    1,32'h3010,32'h3010,0,32'hfc01));
    vt.push_back(mk(1,32'h3018,0,10,0,0,13,0,0,
                    0,32'h3010,32'h3010,0,32'h10));
    vt.push_back(mk(1,32'h3010,1,12,0,0,13,0,0,
                    1,32'h4180,32'h300c,1,32'h80000030));
    vt.push_back(mk(0,0,0,0,0,0,14,0,0,
                    0,32'h4180,32'h300c,1,32'h300c));
    vt.push_back(mk(1,32'h3014,0,0,0,0,12,0,1,
                    1,32'h300c,32'h300c,0,32'hfc01));
    vt.push_back(mk(0,32'h3020,0,4,0,0,12,0,0,
                    0,32'h300c,32'h300c,0,32'hfc01));
    vt.push_back(mk(1,32'h3020,0,5,6'h04,0,13,0,0,
                    1,32'h4180,32'h3020,1,32'h1000));
    vt.push_back(mk(0,0,0,0,6'h04,0,13,0,0,
                    0,32'h4180,32'h3020,1,32'h1000));
    vt.push_back(mk(1,32'h3040,0,5,6'h04,0,13,0,0,
                    1,32'h4180,32'h3020,1,32'h1014));
    vt.push_back(mk(0,0,0,0,0,0,14,0,0,
                    0,32'h4180,32'h3020,1,32'h3020));
    vt.push_back(mk(1,32'h3044,0,0,0,0,12,0,1,
                    1,32'h3020,32'h3020,0,32'hfc01));
    vt.push_back(mk(0,0,0,0,0,0,12,0,0,
                    0,32'h3020,32'h3020,0,32'hfc01));
    vt.push_back(mk(1,32'h3050,0,4,0,1,12,32'h3,0,
                    1,32'h4180,32'h3050,1,32'hfc03));
    vt.push_back(mk(1,32'h3054,0,0,0,1,14,32'h1234,0,
                    0,32'h4180,32'h3050,1,32'h3050));
    vt.push_back(mk(1,32'h3058,0,0,0,1,14,32'h5557,0,
                    0,32'h4180,32'h5554,1,32'h5554));
    vt.push_back(mk(1,32'h305c,0,0,0,1,12,32'h401,0,
                    0,32'h4180,32'h5554,0,32'h401));
    vt.push_back(mk(0,0,0,0,6'h04,0,13,0,0,
                    0,32'h4180,32'h5554,0,32'h1010));
    vt.push_back(mk(0,32'h3060,0,0,6'h01,0,13,0,0,
                    1,32'h4180,32'h3060,1,32'h400));
    vt.push_back(mk(0,0,0,0,0,0,13,0,0,
                    0,32'h4180,32'h3060,1,32'h0));
    vt.push_back(mk(1,32'h3064,0,0,0,1,13,32'hffffffff,0,
                    0,32'h4180,32'h3060,1,32'h0));
    vt.push_back(mk(1,32'h3068,0,0,0,1,15,32'h0,0,
                    0,32'h4180,32'h3060,1,PRID));
    vt.push_back(mk(1,32'h306c,0,0,0,1,7,32'hffff,0,
                    0,32'h4180,32'h3060,1,32'h0));
    vt.push_back(mk(0,0,0,0,0,1,12,32'h0,1,
                    0,32'h4180,32'h3060,1,32'h403));

    foreach (vt[i]) begin
      valid_m = vt[i].valid; pc_m = vt[i].pc; bd_m = vt[i].bd;
      exc_code_m = vt[i].exc; hwint = vt[i].hw; cp0_we = vt[i].we;
      cp0_addr = vt[i].addr; cp0_din = vt[i].din;
      eret_m = vt[i].eret;
      tick();
      chk($sformatf("v%0d_flush", i), {31'd0, flush},
          {31'd0, vt[i].e_flush});
      chk($sformatf("v%0d_redir", i), redirect_pc, vt[i].e_redir);
      chk($sformatf("v%0d_epc", i), epc_out, vt[i].e_epc);
      chk($sformatf("v%0d_exl", i), {31'd0, exl},
          {31'd0, vt[i].e_exl});
      chk($sformatf("v%0d_dout", i), cp0_dout, vt[i].e_dout);
    end

    // mfc0 alongside mtc0 sees the old EPC until the edge.
    idle();
    valid_m = 1; cp0_we = 1; cp0_addr = 5'd14; cp0_din = 32'h8888;
    #1;
    chk("mfc0_old", cp0_dout, 32'h3060);
    tick();
    chk("mfc0_new", cp0_dout, 32'h8888);

    // Reset landing in the FLUSH cycle.
    idle();
    valid_m = 1; pc_m = 32'h3070; exc_code_m = 5'd12;
    tick();
    chk("rf_flush1", {31'd0, flush}, 32'd1);
    idle();
    reset = 1;
    tick();
    reset = 0;
    chk("rf_flush0", {31'd0, flush}, 32'd0);
    chk("rf_redir", redirect_pc, 32'd0);
    chk("rf_exl", {31'd0, exl}, 32'd0);
    valid_m = 1; pc_m = 32'h3080; exc_code_m = 5'd10;
    tick();
    chk("rf_again", {31'd0, flush}, 32'd1);
    chk("rf_epc", epc_out, 32'h3080);
    idle();
    tick();
    chk("rf_drop", {31'd0, flush}, 32'd0);

`ifdef CP0_COUNT_EN
    begin
      bit seen;
      idle();
      reset = 1;
      tick();
      reset = 0;
      valid_m = 1; cp0_we = 1; cp0_addr = 5'd11; cp0_din = 32'd5;
      tick();
      cp0_addr = 5'd9; cp0_din = 32'd0;
      tick();
      idle();
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (flush) seen = 1;
      end
      chk("tmr_taken", {31'd0, seen}, 32'd1);
      cp0_addr = 5'd13; #1;
      chk("tmr_cause", cp0_dout & 32'h0000807c, 32'h00008000);
    end
`else
    idle();
    valid_m = 1; cp0_we = 1; cp0_addr = 5'd9; cp0_din = 32'h77;
    tick();
    chk("cnt_absent", cp0_dout, 32'd0);
    cp0_addr = 5'd11; #1;
    chk("cmp_absent", cp0_dout, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 register file and exception/interrupt sequencer for the 5-stage MIPS pipeline.
- Takes the M-stage exception code from the exception detector, plus hardware interrupt lines, mtc0/mfc0 and eret.
- Updates SR, Cause and EPC.
- Issues a registered one-cycle flush with a redirect PC, either to the handler or back to EPC.

Parameters:
- HANDLER_ADDR, 32'h00004180, exception entry PC.
- PRID_VAL, 32'h20180103, read-only PRId (reg 15) contents.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid_m  in  1  M stage holds a real (non-bubble) instruction
- pc_m  in  32  PC of the M-stage instruction
- bd_m  in  1  M-stage instruction is in a branch delay slot
- exc_code_m  in  5  ExcCode from the detector; 0 means none (4 AdEL, 5 AdES, 10 RI, 12 Ov)
- hwint  in  6  external interrupt lines
- cp0_we  in  1  mtc0 in M stage
- cp0_addr  in  5  CP0 register number for mtc0/mfc0
- cp0_din  in  32  mtc0 write data
- eret_m  in  1  eret in M stage
- cp0_dout  out  32  mfc0 read data, combinational on cp0_addr
- epc_out  out  32  current EPC
- flush  out  1  one-cycle pipeline flush pulse
- redirect_pc  out  32  next fetch PC, valid while flush=1
- exl  out  1  SR.EXL

Behaviour:
- Reset values:
  - SR: IM=6'h3f, EXL=0, IE=1.
  - Cause=0, EPC=0.
  - flush=0, redirect_pc=0, state=RUN.
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC(14): bits [1:0] are always stored as 0.
  - PRId(15) reads PRID_VAL.
  - Undefined addresses read 0.
- Cause.IP samples hwint every cycle; it is not software-writable.
- mtc0 writes SR and EPC only; writes to Cause and PRId are ignored.
- int_req = (|(hwint & SR.IM)) & SR.IE & ~SR.EXL.
- exc_req = valid_m & (exc_code_m != 0).
- FSM states: RUN, FLUSH.
- RUN state, evaluated each posedge, highest priority first:
  1. int_req: ExcCode<=0, then perform entry.
  2. exc_req: ExcCode<=exc_code_m, then perform entry.
  3. valid_m & eret_m: EXL<=0, redirect_pc<=EPC, flush<=1, state<=FLUSH.
  4. valid_m & cp0_we: register write.
- Entry performs:
  - If EXL was 0: EPC <= bd_m ? pc_m-4 : pc_m, and BD<=bd_m. If EXL was 1, EPC and BD are unchanged.
  - EXL<=1, redirect_pc<=HANDLER_ADDR, flush<=1, state<=FLUSH.
- Any exception, interrupt or eret in the same cycle as an mtc0 discards the mtc0.
- FLUSH state:
  - flush stays high for exactly this one cycle; state<=RUN.
  - All M-stage inputs are ignored, since they belong to flushed instructions; no register writes, no new entry.
- Interrupt with valid_m=0: EPC<=pc_m; the pipeline keeps pc_m equal to the oldest unretired PC.
- Latency: the event is sampled at edge t; flush and redirect_pc are visible in cycle t+1.
- cp0_dout forwards nothing: a mfc0 issued with an mtc0 in the same cycle reads the old value.
- epc_out reflects the registered EPC.
- reset during FLUSH returns to RUN with flush=0 at the next edge.

Optional Feature:
- Macro CP0_COUNT_EN.
- When defined:
  - Adds Count(9), incrementing each cycle and wrapping 32'hffffffff->0, mtc0-writable; a written value takes precedence over the increment.
  - Adds Compare(11), mtc0-writable; a Compare write clears the timer pending flag.
  - Timer pending is set when Count==Compare and is ORed into hwint[5] before IP sampling and masking.
- When not defined: regs 9 and 11 read 0, writes are ignored, and there is no timer interrupt.

Test Plan:
- Reset, then mfc0 reg 12 -> 32'h0000fc01; reg 15 -> PRID_VAL; reg 13 -> 0.
- valid_m=1, pc_m=32'h3010, exc_code_m=4, bd_m=0 ->
  - next cycle: flush=1, redirect_pc=32'h4180; EPC=32'h3010; Cause[6:2]=4; EXL=1.
  - following cycle: flush=0.
- Same as above with bd_m=1, exc_code_m=12 -> EPC=32'h300c, Cause[31]=1, ExcCode=12.
- hwint=6'b000100 and exc_code_m=5 in the same cycle -> ExcCode=0 (interrupt wins). Repeat with EXL=1 -> int_req is masked and the AdES entry occurs with EPC unchanged.
- eret with EPC=32'h3010 -> flush=1, redirect_pc=32'h3010, EXL=0. An exc_code_m=10 presented during the FLUSH cycle is ignored: no second flush, Cause unchanged.
- mtc0 reg 12 with 32'h0000fc03 plus an exception the same cycle -> SR write lost, EXL=1. CP0_COUNT_EN: Compare=5 after Count reset -> hwint[5] pending at Count==5; an interrupt is taken if IM[15]=1.
